press_mode_ctrl: RTL and testbench
==================================

# press_mode_ctrl

Press classifier and mode selector sitting directly downstream of the push-button debouncer in the proximity design. It consumes the debouncer's one-cycle rising-edge pulse and classifies each press as a single press or a double press using a programmable time window. It maintains the operating-mode register used by the rest of the system: a single press advances the mode with wrap-around, and a double press returns it to mode 0.

## Interface
- WINDOW, 25_000_000 — double-press window in clk cycles (0.5 s at 50 MHz); legal range ≥ 2
- NUM_MODES, 4 — number of modes; legal range 1 .. 2**MODE_W
- MODE_W, 2 — width of mode output
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- button_edge  input  1  one-cycle press pulse from the debouncer; already synchronous to clk
- mode  output  MODE_W  current mode, registered
- single_press  output  1  one-cycle pulse: press classified as single
- double_press  output  1  one-cycle pulse: press classified as double
- mode_changed  output  1  one-cycle pulse: mode value differs from the previous cycle
- busy  output  1  high while waiting for a possible second press (state WAIT)

## Operation
- FSM states: IDLE and WAIT. Timer width is $clog2(WINDOW+1); the counter never wraps.
- IDLE:
  - button_edge=1 → go to WAIT, timer←0.
  - button_edge=0 → stay in IDLE.
- WAIT, evaluated at each posedge in this priority order:
  - button_edge=1 → double press: double_press pulse, mode←0, go to IDLE.
  - Else timer==WINDOW-1 → single press: single_press pulse, mode←(mode==NUM_MODES-1 ? 0 : mode+1), go to IDLE.
  - Else timer←timer+1, stay in WAIT.
- Simultaneous second press and timeout (button_edge=1 while timer==WINDOW-1): classified as double.
- A third press after a double press is handled from IDLE and starts a new sequence; it is never merged with the previous one.
- mode_changed asserts only when the registered mode value actually changes:
  - double press while mode==0 → mode_changed=0
  - NUM_MODES=1 single press → mode stays 0, mode_changed=0
- At most one of single_press and double_press is high in any cycle.
- button_edge held high for several cycles (out-of-contract input): the first cycle starts WAIT and the next cycle counts as the second press (double).

## Timing
- Reset, all values at the posedge where reset=1, overriding every other input:
  - state=IDLE, timer=0, mode=0
  - single_press=0, double_press=0, mode_changed=0, busy=0
- Reset mid-WAIT abandons the pending press; no pulse is produced.
- Define the first press as sampled at posedge 0. A second press sampled at posedges 1..WINDOW is a double.
- Decision latency:
  - Double: decided at the posedge sampling the second press.
  - Single: decided at posedge WINDOW.
  - In both cases the pulse and the new mode are visible from that posedge until the next one (registered outputs, exactly one cycle).
- busy is high from posedge 0 up to the decision posedge, then low.
- A press sampled at the decision posedge+1 or later is seen in IDLE and starts a new sequence.
- All outputs are registered; there are no combinational paths from button_edge to any output.

## Test plan
- Reset: assert reset 3 cycles with button_edge pulsing → mode=0, all pulses 0, busy=0 throughout; release → still idle.
- Single press (WINDOW=8, NUM_MODES=4): pulse at posedge 0 → busy high for cycles 0–7; single_press and mode_changed high for one cycle after posedge 8; mode 0→1. Repeat 4 times → mode sequence 1,2,3,0 (wrap).
- Double press: mode=2, pulses at posedges 0 and 3 → double_press high for one cycle after posedge 3, mode=0, mode_changed=1, no single_press. Repeat with mode=0 → double_press=1, mode_changed=0.
- Window boundaries (WINDOW=8): second pulse at posedge 8 → double. Second pulse at posedge 9 → single at posedge 8, then a new WAIT starting at 9, resolving to single at posedge 17; mode advances by 2 in total.
- Reset mid-WAIT: pulse at posedge 0, reset at posedge 4 → no pulse ever, mode=0; a press after reset behaves normally.
- Back-to-back: pulses at 0, 2, 4 → double at 2; pulse at 4 starts a new WAIT → single at posedge 12.

Source files
------------

// File: rtl/press_mode_ctrl.sv
// ---------------------------------------------------------------------------
// press_mode_ctrl
//
// Classifies debounced button presses as single or double presses using a
// programmable time window, and maintains the system operating mode.
// A single press advances the mode (wrapping at NUM_MODES-1 back to 0);
// a double press forces the mode back to 0.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   button_edge  in   one-cycle press pulse from the debouncer
//   mode         out  current operating mode (registered)
//   single_press out  one-cycle pulse, press classified as single
//   double_press out  one-cycle pulse, press classified as double
//   mode_changed out  one-cycle pulse, mode differs from the previous cycle
//   busy         out  high while waiting for a possible second press
// ---------------------------------------------------------------------------
module press_mode_ctrl #(
    parameter int WINDOW    = 25_000_000,
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button_edge,
    output logic [MODE_W-1:0] mode,
    output logic              single_press,
    output logic              double_press,
    output logic              mode_changed,
    output logic              busy
);

    localparam int TIMER_W = $clog2(WINDOW + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
    localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_MODES - 1);

    logic [0:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [MODE_W-1:0]  r_mode;
    logic               r_single;
    logic               r_double;
    logic               r_changed;

    logic [0:0]         w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [MODE_W-1:0]  w_mode_nxt;
    logic               w_single;
    logic               w_double;

    // Next-state decode. Within WAIT a second press takes priority over the
    // timeout, so a press landing on the last window cycle is a double.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_mode_nxt  = r_mode;
        w_single    = 1'b0;
        w_double    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (button_edge) begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (button_edge) begin
                    w_double    = 1'b1;
                    w_mode_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    w_single    = 1'b1;
                    w_mode_nxt  = (r_mode == MODE_LAST) ? '0 : r_mode + MODE_W'(1);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_mode    <= '0;
            r_single  <= 1'b0;
            r_double  <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_mode    <= w_mode_nxt;
            r_single  <= w_single;
            r_double  <= w_double;
            // Flag only real value changes: a double press at mode 0, or a
            // single press with one mode, leaves the register untouched.
            r_changed <= (w_mode_nxt != r_mode);
        end
    end

    assign mode         = r_mode;
    assign single_press = r_single;
    assign double_press = r_double;
    assign mode_changed = r_changed;
    assign busy         = (r_state == ST_WAIT);

endmodule

// File: tb/tb_press_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_press_mode_ctrl
//
// Self-checking bench for press_mode_ctrl with WINDOW=8, NUM_MODES=4.
// Expected outputs come from a timestamp-based model: each press records
// the cycle it arrived, and the classification is made from the elapsed
// cycle count against the window.
// ---------------------------------------------------------------------------
module tb_press_mode_ctrl;

    localparam int WINDOW    = 8;
    localparam int NUM_MODES = 4;
    localparam int MODE_W    = 2;

    logic              clk;
    logic              reset;
    logic              button_edge;
    logic [MODE_W-1:0] mode;
    logic              single_press;
    logic              double_press;
    logic              mode_changed;
    logic              busy;

    press_mode_ctrl #(
        .WINDOW    (WINDOW),
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .button_edge  (button_edge),
        .mode         (mode),
        .single_press (single_press),
        .double_press (double_press),
        .mode_changed (mode_changed),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycle counter, cycle of the pending first
    // press (-1 when none), and the expected outputs after each edge.
    int cyc      = 0;
    int pend     = -1;
    int m_mode   = 0;
    int e_single = 0;
    int e_double = 0;
    int e_change = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e);
        int old_mode;
        old_mode = m_mode;
        e_single = 0;
        e_double = 0;
        if (r) begin
            pend   = -1;
            m_mode = 0;
        end else if (pend < 0) begin
            if (e) pend = cyc;
        end else if (e) begin
            e_double = 1;
            m_mode   = 0;
            pend     = -1;
        end else if (cyc - pend == WINDOW) begin
            e_single = 1;
            m_mode   = (m_mode + 1) % NUM_MODES;
            pend     = -1;
        end
        e_change = (!r && m_mode != old_mode) ? 1 : 0;
    endtask

    // One clock: drive inputs while clk is low, let the edge happen,
    // advance the model, then sample 1 time unit later.
    task automatic cycle(input bit r, input bit e);
        reset       = r;
        button_edge = e;
        @(posedge clk);
        model_step(r, e);
        #1;
        check("mode",         32'(mode),                        32'(m_mode));
        check("single_press", 32'(single_press),                32'(e_single));
        check("double_press", 32'(double_press),                32'(e_double));
        check("mode_changed", 32'(mode_changed),                32'(e_change));
        check("busy",         32'(busy),                        (pend >= 0) ? 32'd1 : 32'd0);
        check("one_hot",      32'(single_press & double_press), 32'd0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        button_edge = 1'b0;
        @(negedge clk);

        // Reset held with the button pulsing, then released.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        idle(3);

        // Four single presses: mode walks 1,2,3,0.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1);
            idle(WINDOW + 2);
        end

        // Reach mode 2, then double press (second pulse 3 cycles later).
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1);
            idle(WINDOW + 1);
        end
        cycle(1'b0, 1'b1); idle(2); cycle(1'b0, 1'b1); idle(3);
        // Double press again while already at mode 0.
        cycle(1'b0, 1'b1); idle(2); cycle(1'b0, 1'b1); idle(3);

        // Second press exactly at the last in-window posedge: double.
        cycle(1'b0, 1'b1); idle(WINDOW - 1); cycle(1'b0, 1'b1); idle(3);
        // Second press one cycle too late: single, then a fresh single.
        cycle(1'b0, 1'b1); idle(WINDOW); cycle(1'b0, 1'b1); idle(WINDOW + 3);

        // Reset in the middle of a wait abandons the press.
        cycle(1'b0, 1'b1); idle(3); cycle(1'b1, 1'b0); idle(WINDOW + 3);
        cycle(1'b0, 1'b1); idle(WINDOW + 2);

        // Back-to-back pulses at 0, 2, 4.
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0); cycle(1'b0, 1'b1); idle(WINDOW + 3);

        // Button held high for several cycles.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        idle(WINDOW + 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
